// File: rtl/mem_controller.sv
// Memory-stage controller for the 48-bit CPU: decodes M-stage accesses to the
// external data RAM and to the internal TX FIFO, cycle counter and compare timer.
module mem_controller #(
    parameter int DATA_W     = 48,
    parameter int FIFO_DEPTH = 8,
    parameter int RAM_AW     = 13
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                MemWriteM,
    input  logic [DATA_W-1:0]   ALUOutM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [2:0]          MemoryControl,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                timer_irq,
    output logic                bus_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TXDATA,
        REG_TXSTAT,
        REG_CYCLE,
        REG_CMP,
        REG_TSTAT,
        REG_NONE
    } region_t;

    region_t           w_region;
    logic [15:0]       w_addr;
    logic              w_act;
    logic              w_byte;
    logic              w_store;
    logic              w_load;
    logic              w_unused;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_overflow;
    logic [DATA_W-1:0] w_txstat;

    logic [DATA_W-1:0] r_cyc;
    logic [DATA_W-1:0] w_cyc_next;
    logic [DATA_W-1:0] r_cmp;
    logic              r_flag;
    logic              r_bus_err;
    logic              w_cmp_wr;
    logic              w_tstat_wr;

    assign w_addr   = ALUOutM[15:0];
    assign w_act    = MemoryControl[0];
    assign w_byte   = MemoryControl[1];
    assign w_store  = w_act & MemWriteM;
    assign w_load   = w_act & ~MemWriteM;
    assign w_unused = ^{ALUOutM[DATA_W-1:16], MemoryControl[2]};

    always_comb begin
        w_region = REG_NONE;
        if (!w_addr[15]) begin
            w_region = REG_RAM;
        end else begin
            case (w_addr)
                16'h8000: w_region = REG_TXDATA;
                16'h8004: w_region = REG_TXSTAT;
                16'h8008: w_region = REG_CYCLE;
                16'h800C: w_region = REG_CMP;
                16'h8010: w_region = REG_TSTAT;
                default:  w_region = REG_NONE;
            endcase
        end
    end

    assign ram_addr  = ALUOutM[RAM_AW+1:2];
    assign ram_wdata = WriteDataM;
    assign ram_we    = w_store & (w_region == REG_RAM) & ~Reset;
    assign ram_be    = w_byte ? {{(DATA_W/8-1){1'b0}}, 1'b1} : '1;

    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = tx_valid & tx_ready;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
    assign w_push     = w_store & (w_region == REG_TXDATA) & (~w_full | w_pop);
    assign w_overflow = w_store & (w_region == REG_TXDATA) & w_full & ~w_pop;

    assign tx_valid = ~w_empty;
    assign tx_data  = w_empty ? '0 : r_mem[r_rptr];

    always_comb begin
        w_txstat      = '0;
        w_txstat[6:2] = 5'(r_count);
        w_txstat[1]   = w_empty;
        w_txstat[0]   = w_full;
    end

    assign w_cyc_next = r_cyc + 1'b1;
    assign w_cmp_wr   = w_store & (w_region == REG_CMP);
    assign w_tstat_wr = w_store & (w_region == REG_TSTAT);
    assign timer_irq  = r_flag;
    assign bus_err    = r_bus_err;

    always_comb begin
        ReadDataM = '0;
        if (w_load) begin
            case (w_region)
                REG_RAM:    ReadDataM = w_byte ? {{(DATA_W-8){1'b0}}, ram_rdata[7:0]} : ram_rdata;
                REG_TXSTAT: ReadDataM = w_txstat;
                REG_CYCLE:  ReadDataM = r_cyc;
                REG_CMP:    ReadDataM = r_cmp;
                REG_TSTAT:  ReadDataM = {{(DATA_W-1){1'b0}}, r_flag};
                default:    ReadDataM = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= WriteDataM[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Priority: CMP store clears and suppresses the match, then TSTAT clear, then set.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cyc     <= '0;
            r_cmp     <= '0;
            r_flag    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_cyc <= w_cyc_next;
            if (w_cmp_wr) begin
                r_cmp  <= WriteDataM;
                r_flag <= 1'b0;
            end else if (w_tstat_wr) begin
                r_flag <= 1'b0;
            end else if (w_cyc_next == r_cmp) begin
                r_flag <= 1'b1;
            end
            if ((w_act & (w_region == REG_NONE)) | w_overflow) begin
                r_bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed self-checking bench for mem_controller: a vector table for the
// address decode / RAM path plus hand-written FIFO, timer and bus-error sequences.
module tb_mem_controller;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWriteM;
    logic [47:0] ALUOutM;
    logic [47:0] WriteDataM;
    logic [2:0]  MemoryControl;
    logic [47:0] ReadDataM;
    logic [12:0] ram_addr;
    logic [47:0] ram_wdata;
    logic        ram_we;
    logic [5:0]  ram_be;
    logic [47:0] ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;
    logic        bus_err;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [47:0] model_cyc;

    always #5 CLK = ~CLK;

    mem_controller #(.DATA_W(48), .FIFO_DEPTH(8), .RAM_AW(13)) dut (
        .CLK(CLK), .Reset(Reset), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .MemoryControl(MemoryControl), .ReadDataM(ReadDataM),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_be(ram_be),
        .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .timer_irq(timer_irq), .bus_err(bus_err)
    );

    typedef struct {
        logic        we;
        logic [47:0] addr;
        logic [47:0] wdata;
        logic [2:0]  mctl;
        logic [47:0] rdata;
        logic        chk_rd;
        logic [47:0] exp_rd;
        logic        exp_we;
        logic [5:0]  exp_be;
        logic [12:0] exp_addr;
    } vec_t;

    vec_t vecs [12];
    logic [7:0] drain_exp [8];

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Advance one clock edge; counter model follows the Reset level seen at that edge.
    task automatic step();
        @(posedge CLK);
        #1;
        if (Reset) model_cyc = '0;
        else       model_cyc = model_cyc + 48'd1;
    endtask

    task automatic idle();
        MemWriteM     = 1'b0;
        MemoryControl = 3'b000;
        ALUOutM       = '0;
        WriteDataM    = '0;
    endtask

    task automatic load(input logic [47:0] addr);
        MemWriteM     = 1'b0;
        MemoryControl = 3'b001;
        ALUOutM       = addr;
        WriteDataM    = '0;
    endtask

    task automatic store(input logic [47:0] addr, input logic [47:0] data);
        MemWriteM     = 1'b1;
        MemoryControl = 3'b001;
        ALUOutM       = addr;
        WriteDataM    = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 48'h0010, 48'h123456789ABC, 3'b001, 48'h0, 1'b0, 48'h0, 1'b1, 6'h3F, 13'h0004};
        vecs[1]  = '{1'b0, 48'h0010, 48'h0, 3'b011, 48'h123456789ABC, 1'b1, 48'hBC, 1'b0, 6'h01, 13'h0004};
        vecs[2]  = '{1'b0, 48'h0010, 48'h0, 3'b001, 48'h123456789ABC, 1'b1, 48'h123456789ABC, 1'b0, 6'h3F, 13'h0004};
        vecs[3]  = '{1'b1, 48'h7FFF, 48'hAA, 3'b011, 48'h0, 1'b0, 48'h0, 1'b1, 6'h01, 13'h1FFF};
        vecs[4]  = '{1'b1, 48'h0020, 48'h77, 3'b000, 48'h5555, 1'b1, 48'h0, 1'b0, 6'h3F, 13'h0008};
        vecs[5]  = '{1'b0, 48'h0010, 48'h0, 3'b100, 48'hDEAD, 1'b1, 48'h0, 1'b0, 6'h3F, 13'h0004};
        vecs[6]  = '{1'b0, 48'hABCD00008004, 48'h0, 3'b001, 48'hFFFF, 1'b1, 48'h2, 1'b0, 6'h3F, 13'h0001};
        vecs[7]  = '{1'b0, 48'h800C, 48'h0, 3'b001, 48'hFFFF, 1'b1, 48'h0, 1'b0, 6'h3F, 13'h0003};
        vecs[8]  = '{1'b0, 48'h8010, 48'h0, 3'b001, 48'hFFFF, 1'b1, 48'h0, 1'b0, 6'h3F, 13'h0004};
        vecs[9]  = '{1'b0, 48'h8000, 48'h0, 3'b001, 48'hFFFF, 1'b1, 48'h0, 1'b0, 6'h3F, 13'h0000};
        vecs[10] = '{1'b0, 48'h000000010010, 48'h0, 3'b001, 48'h0BADF00D0001, 1'b1, 48'h0BADF00D0001, 1'b0, 6'h3F, 13'h0004};
        vecs[11] = '{1'b1, 48'h8008, 48'h999, 3'b001, 48'h0, 1'b0, 48'h0, 1'b0, 6'h3F, 13'h0002};
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h55};

        model_cyc = '0;
        tx_ready  = 1'b0;
        ram_rdata = '0;
        Reset     = 1'b1;
        store(48'h0010, 48'h1);
        #2;
        chk("ram_we_in_reset", {47'b0, ram_we}, 48'h0);
        step();
        step();
        Reset = 1'b0;
        idle();
        chk("rst_tx_valid", {47'b0, tx_valid}, 48'h0);
        chk("rst_tx_data", {40'b0, tx_data}, 48'h0);
        chk("rst_timer_irq", {47'b0, timer_irq}, 48'h0);
        chk("rst_bus_err", {47'b0, bus_err}, 48'h0);

        for (int i = 0; i < 5; i++) step();
        chk("idle_tx_valid", {47'b0, tx_valid}, 48'h0);
        load(48'h8008);
        #2;
        chk("cycle_after_5", ReadDataM, 48'd5);
        step();

        for (int i = 0; i < 12; i++) begin
            MemWriteM     = vecs[i].we;
            ALUOutM       = vecs[i].addr;
            WriteDataM    = vecs[i].wdata;
            MemoryControl = vecs[i].mctl;
            ram_rdata     = vecs[i].rdata;
            #2;
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), ReadDataM, vecs[i].exp_rd);
            chk($sformatf("vec%0d_we", i), {47'b0, ram_we}, {47'b0, vecs[i].exp_we});
            chk($sformatf("vec%0d_be", i), {42'b0, ram_be}, {42'b0, vecs[i].exp_be});
            chk($sformatf("vec%0d_addr", i), {35'b0, ram_addr}, {35'b0, vecs[i].exp_addr});
            chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].wdata);
            step();
        end
        idle();
        ram_rdata = '0;
        chk("table_bus_err", {47'b0, bus_err}, 48'h0);
        load(48'h8008);
        #2;
        chk("cycle_after_store", ReadDataM, model_cyc);
        step();

        for (int i = 0; i < 8; i++) begin
            store(48'h8000, 48'hFFFFFFFFFF00 | 48'(8'h41 + 8'(i)));
            step();
        end
        load(48'h8004);
        #2;
        chk("txstat_full", ReadDataM, 48'h21);
        chk("full_tx_valid", {47'b0, tx_valid}, 48'h1);
        chk("full_head", {40'b0, tx_data}, 48'h41);
        chk("pre_ovf_bus_err", {47'b0, bus_err}, 48'h0);
        step();
        store(48'h8000, 48'h49);
        step();
        idle();
        chk("ovf_bus_err", {47'b0, bus_err}, 48'h1);
        load(48'h8004);
        #2;
        chk("txstat_after_ovf", ReadDataM, 48'h21);
        step();

        store(48'h8000, 48'h55);
        tx_ready = 1'b1;
        #2;
        chk("pushpop_head", {40'b0, tx_data}, 48'h41);
        step();
        tx_ready = 1'b0;
        load(48'h8004);
        #2;
        chk("txstat_pushpop", ReadDataM, 48'h21);
        step();
        idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), {47'b0, tx_valid}, 48'h1);
            chk($sformatf("drain%0d_data", i), {40'b0, tx_data}, {40'b0, drain_exp[i]});
            step();
        end
        chk("drained_valid", {47'b0, tx_valid}, 48'h0);
        chk("drained_data", {40'b0, tx_data}, 48'h0);
        load(48'h8004);
        #2;
        chk("txstat_empty", ReadDataM, 48'h2);
        step();
        tx_ready = 1'b0;

        Reset = 1'b1;
        store(48'h8000, 48'h99);
        step();
        Reset = 1'b0;
        idle();
        chk("rst2_tx_valid", {47'b0, tx_valid}, 48'h0);
        chk("rst2_bus_err", {47'b0, bus_err}, 48'h0);

        for (int k = 0; k < 10 && model_cyc != 48'd3; k++) step();
        store(48'h800C, 48'd10);
        step();
        idle();
        load(48'h800C);
        #2;
        chk("cmp_readback", ReadDataM, 48'd10);
        idle();
        for (int k = 0; k < 20 && model_cyc < 48'd9; k++) begin
            chk($sformatf("irq_low_at_%0d", model_cyc), {47'b0, timer_irq}, 48'h0);
            step();
        end
        chk("irq_low_at_9", {47'b0, timer_irq}, 48'h0);
        step();
        chk("irq_set_at_10", {47'b0, timer_irq}, 48'h1);
        load(48'h8010);
        #2;
        chk("tstat_read", ReadDataM, 48'h1);
        step();
        idle();
        chk("irq_held", {47'b0, timer_irq}, 48'h1);
        store(48'h8010, 48'h0);
        step();
        idle();
        chk("irq_cleared", {47'b0, timer_irq}, 48'h0);

        store(48'h800C, model_cyc + 48'd3);
        step();
        idle();
        step();
        store(48'h8010, 48'hABC);
        step();
        idle();
        chk("clear_beats_set", {47'b0, timer_irq}, 48'h0);
        store(48'h800C, model_cyc + 48'd1);
        step();
        idle();
        chk("cmp_store_no_set", {47'b0, timer_irq}, 48'h0);

        MemWriteM     = 1'b0;
        MemoryControl = 3'b000;
        ALUOutM       = 48'h9000;
        #2;
        chk("unmapped_noact_rd", ReadDataM, 48'h0);
        step();
        chk("unmapped_noact_err", {47'b0, bus_err}, 48'h0);
        load(48'h9000);
        #2;
        chk("unmapped_rd", ReadDataM, 48'h0);
        step();
        idle();
        chk("unmapped_err", {47'b0, bus_err}, 48'h1);
        step();
        chk("bus_err_sticky", {47'b0, bus_err}, 48'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
Memory-stage controller directly downstream of the 48-bit pipelined CPU. It consumes the CPU's M-stage outputs (MemWriteM, ALUOutM, WriteDataM, MemoryControl) and returns ReadDataM in the same cycle. It decodes addresses to an external data RAM and to internal memory-mapped peripherals: a TX byte FIFO with a valid/ready drain port, a free-running cycle counter, and a compare timer.

Parameters:
DATA_W, 48, data/address width
FIFO_DEPTH, 8, TX FIFO entries (power of 2, 2..16)
RAM_AW, 13, external RAM word-address width

Ports:
CLK  input  1  clock
Reset  input  1  synchronous, active-high reset
MemWriteM  input  1  store strobe from CPU M stage
ALUOutM  input  48  byte address from CPU
WriteDataM  input  48  store data
MemoryControl  input  3  [0] access enable, [1] byte mode, [2] reserved/ignored
ReadDataM  output  48  load data to CPU, combinational
ram_addr  output  RAM_AW  RAM word address = ALUOutM[RAM_AW+1:2]
ram_wdata  output  48  = WriteDataM
ram_we  output  1  RAM write strobe
ram_be  output  6  byte enables
ram_rdata  input  48  RAM async read data
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head
timer_irq  output  1  level; timer expired flag
bus_err  output  1  sticky unmapped-access flag

Behaviour:
- Reset applies on a CLK edge while Reset=1. Reset values: FIFO empty (tx_valid=0, tx_data=0), cycle counter 0, compare 0, timer flag 0 (timer_irq=0), bus_err 0. ram_we is 0 whenever Reset=1.
- Active access: act = MemoryControl[0]. A store is act & MemWriteM; a load is act & ~MemWriteM. When act=0, MemWriteM is ignored.
- Decode uses ALUOutM[15:0]. Upper bits are ignored.
  - RAM: addr < 0x8000.
  - TXDATA: 0x8000.
  - TXSTAT: 0x8004.
  - CYCLE: 0x8008.
  - CMP: 0x800C.
  - TSTAT: 0x8010.
  - Anything else is unmapped.
- RAM path:
  - ram_we = store & RAM.
  - ram_be = 6'b000001 if byte mode, else 6'b111111.
  - Load data = ram_rdata, or {40'b0, ram_rdata[7:0]} in byte mode.
- ReadDataM is combinational and valid in the same cycle (the CPU registers it into W at the next edge).
  - TXSTAT reads {.., count[4:0] at bits[6:2], empty at bit1, full at bit0}, zero-extended.
  - CYCLE reads the counter value before this edge's increment.
  - CMP reads the compare register.
  - TSTAT reads {47'b0, flag}.
  - Unmapped addresses, TXDATA, or act=0 read 0.
- TX FIFO:
  - push = store & TXDATA & ~full. Pushed byte = WriteDataM[7:0].
  - pop = tx_valid & tx_ready.
  - Push and pop in the same cycle: both occur, count unchanged. This includes when full; the pop frees the slot first, so the push is accepted.
  - Push when full with no pop: data dropped, bus_err set.
  - tx_data = head entry; it is 0 when empty.
  - Read/write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Cycle counter: +1 every non-reset cycle, wraps at 2^48-1 -> 0. Stores to CYCLE are ignored.
- Timer:
  - A store to CMP loads the compare register and clears the flag in the same edge.
  - The flag sets when counter_next == compare and no CMP store is occurring this cycle. The flag stays set until cleared.
  - A store to TSTAT (any data) clears the flag. If a set and a TSTAT clear coincide, the clear wins.
  - timer_irq = flag.
- bus_err: set by any active access to an unmapped address, or by FIFO overflow. Cleared only by Reset.
- No stall/handshake to the CPU: every access completes in one cycle.
- Reset mid-operation discards FIFO contents. A simultaneous store in the reset cycle has no effect.

Test Plan:
- Reset then idle 5 cycles -> tx_valid=0, timer_irq=0, bus_err=0; load CYCLE on the 6th post-reset cycle returns 5.
- Store 0x123456789ABC to addr 0x0010, byte mode 0 -> ram_we=1, ram_addr=4, ram_be=6'h3F; load addr 0x0010 in byte mode with ram_rdata=0x123456789ABC -> ReadDataM=0xBC.
- Store bytes 0x41..0x48 to 0x8000 with tx_ready=0 -> TXSTAT reads 0x21 (count 8, full). Ninth store -> bus_err=1 and count stays 8. Raise tx_ready -> bytes 0x41..0x48 emerge in order, then tx_valid=0.
- FIFO full; in one cycle pop (tx_ready=1) and push 0x55 -> count remains 8, and 0x55 is the last byte drained.
- Store 10 to CMP at cycle counter 3 -> timer_irq rises on the edge where the counter becomes 10. Store to TSTAT -> timer_irq=0 next cycle.
- Load from 0x9000 with act=1 -> ReadDataM=0, bus_err=1. Same address with act=0 -> bus_err unchanged.
